// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: controller state encoding
// and the default operand width used by both controller and datapath.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ADD  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int DIV_W = 5;

endpackage

// File: rtl/serial_addsub_if.sv
// Add-start/add-done handshake and operand/result bus between the divider
// controller (master) and the bit-serial adder/subtractor (slave).
interface serial_addsub_if
  import div_pkg::*;
#(
  parameter int N = DIV_W
) ();

  logic         start;
  logic         sub;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [N-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         neg;
  logic         zero;
  logic         busy;
  logic         done;

  modport master (
    output start, sub, a, b,
    input  sum, cout, ovf, neg, zero, busy, done
  );

  modport slave (
    input  start, sub, a, b,
    output sum, cout, ovf, neg, zero, busy, done
  );

endinterface

// File: rtl/fa1.sv
// One-bit combinational full adder used as the serial add/subtract cell.
module fa1 (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic s_o,
  output logic cout_o
);

  assign s_o    = a_i ^ b_i ^ cin_i;
  assign cout_o = (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial N-bit adder/subtractor, LSB first, one bit per clock, with
// carry, signed-overflow, sign and zero flags for the iterative divider.
module serial_addsub
  import div_pkg::*;
#(
  parameter int N = DIV_W
) (
  input  logic           clk,
  input  logic           rst,
  serial_addsub_if.slave bus
);

  localparam int CNT_W = $clog2(N);

  state_t           state_q, state_d;
  logic [N-1:0]     opa_q, opb_q, res_q;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q, cmsb_q, done_q;
  logic             accept, step, last, in_add;
  logic             fa_s, fa_c;

  fa1 u_fa1 (
    .a_i   (opa_q[0]),
    .b_i   (opb_q[0]),
    .cin_i (carry_q),
    .s_o   (fa_s),
    .cout_o(fa_c)
  );

  assign last   = (cnt_q == '0);
  assign in_add = (state_q == ADD);

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = ADD;
          accept  = 1'b1;
        end
      end
      ADD: begin
        step = 1'b1;
        if (last) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cmsb_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      // done is registered off DONE so the pulse lands one cycle after the result settles
      done_q  <= (state_q == DONE);
      if (accept) begin
        opa_q   <= bus.a;
        opb_q   <= bus.b ^ {N{bus.sub}};
        carry_q <= bus.sub;
        cnt_q   <= CNT_W'(N - 1);
        res_q   <= '0;
      end else if (step) begin
        res_q   <= {fa_s, res_q[N-1:1]};
        carry_q <= fa_c;
        opa_q   <= {1'b0, opa_q[N-1:1]};
        opb_q   <= {1'b0, opb_q[N-1:1]};
        cnt_q   <= cnt_q - CNT_W'(1);
        if (last) cmsb_q <= carry_q;
      end
    end
  end

  // Flags are masked while a new result is still shifting in.
  assign bus.sum  = res_q;
  assign bus.cout = carry_q & ~in_add;
  assign bus.ovf  = (cmsb_q ^ carry_q) & ~in_add;
  assign bus.neg  = res_q[N-1] & ~in_add;
  assign bus.zero = (res_q == '0) & ~in_add;
  assign bus.busy = (state_q != IDLE);
  assign bus.done = done_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub: driver pushes expected results from an
// arithmetic reference model, a monitor pops and compares on each done pulse.
module tb_serial_addsub;
  import div_pkg::*;

  localparam int N = DIV_W;
  localparam int M = 1 << N;

  typedef struct {
    logic [N-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         neg;
    logic         zero;
    int           due;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   ndone = 0;
  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_addsub_if #(.N(N)) bus ();

  serial_addsub #(.N(N)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic bail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b, input logic s);
    exp_t e;
    int ai, bi, sa, sb, full, sr;
    ai     = int'(a);
    bi     = int'(b);
    sa     = (ai >= M / 2) ? ai - M : ai;
    sb     = (bi >= M / 2) ? bi - M : bi;
    full   = s ? ai - bi : ai + bi;
    sr     = s ? sa - sb : sa + sb;
    e.sum  = N'((full + M) % M);
    e.cout = s ? (ai >= bi) : (full >= M);
    e.ovf  = (sr > M / 2 - 1) || (sr < -(M / 2));
    e.neg  = e.sum[N-1];
    e.zero = (e.sum == '0);
    e.due  = 0;
    return e;
  endfunction

  task automatic push(input logic [N-1:0] a, input logic [N-1:0] b, input logic s, input int acc);
    exp_t e;
    e     = model(a, b, s);
    e.due = acc + N + 1;
    q.push_back(e);
  endtask

  task automatic wait_idle(output bit ok);
    int w;
    w = 0;
    while (bus.busy && w < 50) begin
      @(negedge clk);
      w++;
    end
    ok = !bus.busy;
  endtask

  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b, input logic s);
    bit ok;
    @(negedge clk);
    wait_idle(ok);
    if (!ok) begin
      bail("issue_wait_idle");
      return;
    end
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.sub   = s;
    push(a, b, s, cyc + 1);
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = N'($urandom);
    bus.b     = N'($urandom);
    bus.sub   = 1'($urandom);
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (q.size() != 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (q.size() != 0) bail("drain");
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_sum"},  32'(bus.sum),  0);
    chk({tag, "_cout"}, 32'(bus.cout), 0);
    chk({tag, "_ovf"},  32'(bus.ovf),  0);
    chk({tag, "_neg"},  32'(bus.neg),  0);
    chk({tag, "_zero"}, 32'(bus.zero), 1);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_done"}, 32'(bus.done), 0);
  endtask

  always @(negedge clk) begin
    if (!rst && bus.done) begin
      ndone++;
      if (q.size() == 0) begin
        bail("unexpected_done");
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("done_latency", 32'(cyc), 32'(e.due));
        chk("sum",  32'(bus.sum),  32'(e.sum));
        chk("cout", 32'(bus.cout), 32'(e.cout));
        chk("ovf",  32'(bus.ovf),  32'(e.ovf));
        chk("neg",  32'(bus.neg),  32'(e.neg));
        chk("zero", 32'(bus.zero), 32'(e.zero));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  d0, acc_n;
    int  acc_cyc[2];
    bit  ok;
    logic [N-1:0] ra, rb;
    logic rs;

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.sub   = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (2) @(negedge clk);
    chk_idle_outputs("reset");
    rst = 1'b0;

    // directed cases from the test plan
    issue(5'd7,  5'd5, 1'b0);
    issue(5'd3,  5'd5, 1'b1);
    issue(5'd15, 5'd1, 1'b0);
    issue(5'd31, 5'd1, 1'b0);
    issue(5'd16, 5'd16, 1'b1);
    issue(5'd0,  5'd16, 1'b1);
    drain();

    // start while busy is ignored
    d0 = ndone;
    issue(5'd1, 5'd1, 1'b0);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 5'd9;
    bus.b     = 5'd3;
    @(negedge clk);
    bus.start = 1'b0;
    drain();
    chk("busy_start_done_count", 32'(ndone - d0), 1);

    // start held high: second op accepted right after DONE
    @(negedge clk);
    wait_idle(ok);
    if (!ok) bail("b2b_wait_idle");
    bus.a     = 5'd6;
    bus.b     = 5'd13;
    bus.sub   = 1'b1;
    bus.start = 1'b1;
    acc_n     = 0;
    for (int i = 0; i < 40 && acc_n < 2; i++) begin
      if (!bus.busy) begin
        push(bus.a, bus.b, bus.sub, cyc + 1);
        acc_cyc[acc_n] = cyc + 1;
        acc_n++;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    chk("b2b_accepts", 32'(acc_n), 2);
    if (acc_n == 2) chk("b2b_spacing", 32'(acc_cyc[1] - acc_cyc[0]), 32'(N + 2));
    drain();

    // reset in ADD cycle 2 aborts without done
    issue(5'd11, 5'd6, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    q.delete();
    #1;
    chk_idle_outputs("abort");
    @(negedge clk);
    rst = 1'b0;
    d0  = ndone;
    repeat (N + 4) @(negedge clk);
    chk("abort_no_done", 32'(ndone - d0), 0);
    issue(5'd12, 5'd9, 1'b1);
    drain();

    // randomized operations with occasional idle gaps
    for (int i = 0; i < 40; i++) begin
      ra = N'($urandom);
      rb = N'($urandom);
      rs = 1'($urandom);
      issue(ra, rb, rs);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
